// File: rtl/usb_rx_nrzi_unstuff.sv
// USB full-speed receive front end: NRZI decode, SYNC hunt, bit unstuffing, byte assembly and EOP detection.
// Optional USB_RX_STUFF_ABORT_EN: a stuff error abandons the packet until the line returns to idle.
module usb_rx_nrzi_unstuff #(
   parameter int         STUFF_LIMIT  = 6,
   parameter logic [7:0] SYNC_PATTERN = 8'h80,
   parameter int         EOP_SE0_MIN  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dplus_sync,
   input  logic       dminus_sync,
   input  logic       shift_enable,
   output logic       rx_bit,
   output logic       rx_bit_valid,
   output logic       crc_reset,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       rx_active,
   output logic       eop,
   output logic       byte_err,
   output logic       stuff_err
);

   localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
   localparam int SE0_W  = $clog2(EOP_SE0_MIN + 1);

   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_K   = 2'b01,
      LINE_J   = 2'b10
   } line_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HUNT,
      S_DATA,
      S_EOP,
      S_ABORT
   } state_t;

   state_t              state;
   line_t               line;
   line_t               prev_line;
   logic                dec_bit;
   logic                is_se0;
   logic [7:0]          sync_sr;
   logic [7:0]          sync_next;
   logic [3:0]          hunt_cnt;
   logic [ONES_W-1:0]   ones_cnt;
   logic [SE0_W-1:0]    se0_cnt;
   logic [2:0]          bit_cnt;
   logic [6:0]          stage;
   logic                seen_se0;

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      line = LINE_SE0;
      if (dplus_sync && !dminus_sync)
         line = LINE_J;
      else if (!dplus_sync && dminus_sync)
         line = LINE_K;
   end

   // A repeated line level decodes as 1, a J<->K transition as 0.
   assign is_se0    = (line == LINE_SE0);
   assign dec_bit   = (line == prev_line);
   assign sync_next = {dec_bit, sync_sr[7:1]};

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         prev_line    <= LINE_J;
         sync_sr      <= '0;
         hunt_cnt     <= '0;
         ones_cnt     <= '0;
         se0_cnt      <= '0;
         bit_cnt      <= '0;
         stage        <= '0;
         seen_se0     <= 1'b0;
         rx_bit       <= 1'b0;
         rx_bit_valid <= 1'b0;
         crc_reset    <= 1'b1;
         rx_byte      <= '0;
         byte_valid   <= 1'b0;
         rx_active    <= 1'b0;
         eop          <= 1'b0;
         byte_err     <= 1'b0;
         stuff_err    <= 1'b0;
      end else begin
         rx_bit_valid <= 1'b0;
         byte_valid   <= 1'b0;
         eop          <= 1'b0;
         byte_err     <= 1'b0;
         stuff_err    <= 1'b0;

         if (shift_enable) begin
            if (!is_se0)
               prev_line <= line;

            case (state)
               S_IDLE: begin
                  if (line == LINE_K) begin
                     state    <= S_HUNT;
                     sync_sr  <= {dec_bit, 7'b0};
                     hunt_cnt <= '0;
                  end
               end

               S_HUNT: begin
                  if (is_se0) begin
                     state <= S_IDLE;
                  end else begin
                     sync_sr <= sync_next;
                     if (sync_next == SYNC_PATTERN) begin
                        state     <= S_DATA;
                        rx_active <= 1'b1;
                        crc_reset <= 1'b0;
                        ones_cnt  <= '0;
                        bit_cnt   <= '0;
                     end else if (hunt_cnt == 4'd15) begin
                        state <= S_IDLE;
                     end else begin
                        hunt_cnt <= hunt_cnt + 1'b1;
                     end
                  end
               end

               S_DATA: begin
                  if (is_se0) begin
                     state   <= S_EOP;
                     se0_cnt <= SE0_W'(1);
                  end else if (ones_cnt == ONES_W'(STUFF_LIMIT)) begin
                     // Stuff slot: the bit is always dropped; a 1 here is a protocol violation.
                     ones_cnt <= '0;
                     if (dec_bit) begin
                        stuff_err <= 1'b1;
`ifdef USB_RX_STUFF_ABORT_EN
                        state     <= S_ABORT;
                        rx_active <= 1'b0;
                        crc_reset <= 1'b1;
                        bit_cnt   <= '0;
                        seen_se0  <= 1'b0;
`endif
                     end
                  end else begin
                     rx_bit       <= dec_bit;
                     rx_bit_valid <= 1'b1;
                     ones_cnt     <= dec_bit ? ones_cnt + 1'b1 : '0;
                     bit_cnt      <= bit_cnt + 1'b1;
                     if (bit_cnt == 3'd7) begin
                        rx_byte    <= {dec_bit, stage};
                        byte_valid <= 1'b1;
                     end else begin
                        stage[bit_cnt] <= dec_bit;
                     end
                  end
               end

               S_EOP: begin
                  if (is_se0) begin
                     if (se0_cnt < SE0_W'(EOP_SE0_MIN))
                        se0_cnt <= se0_cnt + 1'b1;
                  end else begin
                     state     <= S_IDLE;
                     rx_active <= 1'b0;
                     crc_reset <= 1'b1;
                     bit_cnt   <= '0;
                     ones_cnt  <= '0;
                     if (line == LINE_J && se0_cnt >= SE0_W'(EOP_SE0_MIN)) begin
                        eop      <= 1'b1;
                        byte_err <= (bit_cnt != 3'd0);
                     end else begin
                        byte_err <= 1'b1;
                     end
                  end
               end

               S_ABORT: begin
                  if (is_se0)
                     seen_se0 <= 1'b1;
                  else if (line == LINE_J && seen_se0)
                     state <= S_IDLE;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Self-checking bench for usb_rx_nrzi_unstuff: directed packets plus random packets checked against a payload-level model.
module tb_usb_rx_nrzi_unstuff;

   localparam logic [1:0] L_J   = 2'b10;
   localparam logic [1:0] L_K   = 2'b01;
   localparam logic [1:0] L_SE0 = 2'b00;

   logic       tb_clk;
   logic       rst;
   logic       dplus_sync;
   logic       dminus_sync;
   logic       shift_enable;
   logic       rx_bit;
   logic       rx_bit_valid;
   logic       crc_reset;
   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       rx_active;
   logic       eop;
   logic       byte_err;
   logic       stuff_err;

   usb_rx_nrzi_unstuff dut (
      .clk          (tb_clk),
      .rst          (rst),
      .dplus_sync   (dplus_sync),
      .dminus_sync  (dminus_sync),
      .shift_enable (shift_enable),
      .rx_bit       (rx_bit),
      .rx_bit_valid (rx_bit_valid),
      .crc_reset    (crc_reset),
      .rx_byte      (rx_byte),
      .byte_valid   (byte_valid),
      .rx_active    (rx_active),
      .eop          (eop),
      .byte_err     (byte_err),
      .stuff_err    (stuff_err)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   int         vectors     = 0;
   int         miscompares = 0;
   int         max_gap     = 2;
   logic       lvl;
   bit         pay[$];
   bit         exp_bits[$];
   bit         got_bits[$];
   logic [7:0] got_bytes[$];
   int         eop_cnt, berr_cnt, serr_cnt, viol;
   bit         act_seen, crc_low_seen;
   logic       se_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: pulses are collected on the falling edge, and must follow a sampled bit.
   always @(posedge tb_clk) se_q <= shift_enable;

   always @(negedge tb_clk) begin
      if (!rst) begin
         if (rx_bit_valid) got_bits.push_back(rx_bit);
         if (byte_valid)   got_bytes.push_back(rx_byte);
         if (eop)          eop_cnt++;
         if (byte_err)     berr_cnt++;
         if (stuff_err)    serr_cnt++;
         if ((rx_bit_valid || byte_valid || eop || byte_err || stuff_err) && !se_q) viol++;
         if (byte_valid && !rx_bit_valid) viol++;
         if (rx_active)  act_seen = 1'b1;
         if (!crc_reset) crc_low_seen = 1'b1;
      end
   end

   task automatic tick();
      @(negedge tb_clk);
      #1;
   endtask

   // One line sample; returns with that sample's registered response visible.
   task automatic sym(input logic [1:0] s);
      int gap;
      gap = $urandom_range(0, max_gap);
      repeat (gap) tick();
      {dplus_sync, dminus_sync} = s;
      shift_enable = 1'b1;
      tick();
      shift_enable = 1'b0;
   endtask

   task automatic tx_bit(input bit b);
      if (!b) lvl = ~lvl;
      sym(lvl ? L_J : L_K);
   endtask

   task automatic send_idle(input int n);
      repeat (n) sym(L_J);
      lvl = 1'b1;
   endtask

   task automatic send_sync(input bit chk);
      for (int i = 0; i < 8; i++) begin
         tx_bit(i == 7);
         if (chk && i == 6) check("sync7_rx_active", rx_active, 0);
         if (chk && i == 7) begin
            check("sync8_rx_active", rx_active, 1);
            check("sync8_crc_reset", crc_reset, 0);
         end
      end
   endtask

   // Transmitter-side stuffing: a 0 follows every six consecutive payload 1s.
   task automatic send_payload();
      int ones;
      ones = 0;
      foreach (pay[i]) begin
         tx_bit(pay[i]);
         ones = pay[i] ? ones + 1 : 0;
         if (ones == 6) begin
            tx_bit(1'b0);
            ones = 0;
         end
      end
   endtask

   task automatic send_eop(input int n_se0, input bit term_j);
      repeat (n_se0) sym(L_SE0);
      if (term_j) begin
         sym(L_J);
         lvl = 1'b1;
      end else begin
         sym(L_K);
         sym(L_J);
         lvl = 1'b1;
      end
   endtask

   task automatic pay_byte(input logic [7:0] b);
      for (int k = 0; k < 8; k++) pay.push_back(b[k]);
   endtask

   task automatic start_capture();
      got_bits.delete();
      got_bytes.delete();
      eop_cnt = 0; berr_cnt = 0; serr_cnt = 0; viol = 0;
      act_seen = 1'b0; crc_low_seen = 1'b0;
   endtask

   task automatic finish_check(input string tag, input int exp_eop, input int exp_berr, input int exp_serr);
      int nb;
      logic [7:0] eb;
      send_idle(2);
      tick();
      tick();
      nb = exp_bits.size();
      check({tag, ".nbits"}, got_bits.size(), nb);
      for (int i = 0; i < nb; i++)
         if (i < got_bits.size()) check($sformatf("%s.bit%0d", tag, i), got_bits[i], exp_bits[i]);
      check({tag, ".nbytes"}, got_bytes.size(), nb / 8);
      for (int i = 0; i < nb / 8; i++) begin
         for (int k = 0; k < 8; k++) eb[k] = exp_bits[8 * i + k];
         if (i < got_bytes.size()) check($sformatf("%s.byte%0d", tag, i), got_bytes[i], eb);
      end
      check({tag, ".eop"}, eop_cnt, exp_eop);
      check({tag, ".byte_err"}, berr_cnt, exp_berr);
      check({tag, ".stuff_err"}, serr_cnt, exp_serr);
      check({tag, ".timing"}, viol, 0);
      check({tag, ".idle_rx_active"}, rx_active, 0);
      check({tag, ".idle_crc_reset"}, crc_reset, 1);
   endtask

   initial begin
      rst = 1'b1;
      dplus_sync = 1'b1;
      dminus_sync = 1'b0;
      shift_enable = 1'b0;
      lvl = 1'b1;
      repeat (2) tick();
      check("rst.crc_reset", crc_reset, 1);
      check("rst.rx_bit", rx_bit, 0);
      check("rst.rx_bit_valid", rx_bit_valid, 0);
      check("rst.rx_byte", rx_byte, 0);
      check("rst.byte_valid", byte_valid, 0);
      check("rst.rx_active", rx_active, 0);
      check("rst.eop", eop, 0);
      check("rst.byte_err", byte_err, 0);
      check("rst.stuff_err", stuff_err, 0);
      rst = 1'b0;
      tick();

      // Bytes 0x00 and 0x84 with a clean EOP.
      start_capture();
      send_idle(3);
      send_sync(1'b1);
      pay.delete(); pay_byte(8'h00); pay_byte(8'h84);
      send_payload();
      send_eop(2, 1'b1);
      check("p84.eop_now", eop, 1);
      check("p84.byte_err_now", byte_err, 0);
      exp_bits = pay;
      finish_check("p84", 1, 0, 0);

      // 0xFF needs one stuffed zero after six ones.
      start_capture();
      send_idle(1);
      send_sync(1'b0);
      pay.delete(); pay_byte(8'hFF);
      send_payload();
      send_eop(2, 1'b1);
      exp_bits = pay;
      finish_check("pff", 1, 0, 0);

      // Seven unstuffed ones, then two zeros.
      start_capture();
      send_idle(1);
      send_sync(1'b0);
      for (int i = 0; i < 7; i++) begin
         tx_bit(1'b1);
         if (i == 5) check("serr.before", stuff_err, 0);
      end
      check("serr.pulse", stuff_err, 1);
`ifdef USB_RX_STUFF_ABORT_EN
      check("serr.abort_rx_active", rx_active, 0);
      check("serr.abort_crc_reset", crc_reset, 1);
`else
      check("serr.cont_rx_active", rx_active, 1);
`endif
      tx_bit(1'b0);
      tx_bit(1'b0);
      send_eop(2, 1'b1);
      exp_bits.delete();
      repeat (6) exp_bits.push_back(1'b1);
`ifdef USB_RX_STUFF_ABORT_EN
      finish_check("serr", 0, 0, 1);
`else
      repeat (2) exp_bits.push_back(1'b0);
      finish_check("serr", 1, 0, 1);
`endif

      // Partial byte at EOP.
      start_capture();
      send_idle(1);
      send_sync(1'b0);
      pay.delete();
      for (int i = 0; i < 5; i++) pay.push_back(1'($urandom_range(0, 1)));
      send_payload();
      send_eop(2, 1'b1);
      check("part.eop_now", eop, 1);
      check("part.byte_err_now", byte_err, 1);
      exp_bits = pay;
      finish_check("part", 1, 1, 0);

      // SE0 during SYNC hunt.
      start_capture();
      send_idle(2);
      sym(L_K); sym(L_J); sym(L_K); sym(L_J);
      sym(L_SE0);
      sym(L_J);
      lvl = 1'b1;
      exp_bits.delete();
      finish_check("hunt", 0, 0, 0);
      check("hunt.rx_active_seen", act_seen, 0);
      check("hunt.crc_reset_low_seen", crc_low_seen, 0);

      // Reset in the middle of a packet.
      start_capture();
      send_idle(1);
      send_sync(1'b0);
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(1'($urandom_range(0, 1)));
      send_payload();
      rst = 1'b1;
      repeat (2) tick();
      check("mrst.rx_active", rx_active, 0);
      check("mrst.crc_reset", crc_reset, 1);
      rst = 1'b0;
      lvl = 1'b1;
      exp_bits = pay;
      finish_check("mrst", 0, 0, 0);

      // Random packets: random payload density, gaps and EOP shapes.
      for (int p = 0; p < 40; p++) begin
         int  n, n_se0;
         bit  dense, term_j;
         int  e_eop, e_berr;
         max_gap = (p % 4 == 0) ? 0 : 3;
         n = $urandom_range(0, 40);
         dense = ($urandom_range(0, 2) == 0);
         pay.delete();
         for (int i = 0; i < n; i++)
            pay.push_back(dense ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1)));
         n_se0  = $urandom_range(1, 3);
         term_j = ($urandom_range(0, 4) != 0);
         e_eop  = (term_j && n_se0 >= 2) ? 1 : 0;
         e_berr = e_eop ? ((n % 8 != 0) ? 1 : 0) : 1;
         start_capture();
         send_idle($urandom_range(1, 3));
         send_sync(1'b0);
         send_payload();
         send_eop(n_se0, term_j);
         exp_bits = pay;
         finish_check($sformatf("rnd%0d", p), e_eop, e_berr, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
